spi_flash_target: RTL and testbench

- Parametrised, oversampled SPI NOR-flash target. Emulates a serial flash towards an external SPI host.
- Runs entirely on the system clock. SPI clock, chip select and data lines are synchronised into that domain, so no logic is clocked by spi_clk.
- Adds over the previous generation: configurable address width, fast read with dummy cycles, dual-output read, and a generic byte-wide memory request/response port in place of hard-wired SDRAM control.
- Sits between the board SPI pins and the memory/write controller.

---
 rtl/spi_flash_pkg.sv | 37 +++
 rtl/spi_sync_edge.sv | 48 ++++
 rtl/spi_flash_target.sv | 331 +++++++++++++++++++++++++++++++++
 tb/tb_spi_flash_target.sv | 465 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_flash_pkg.sv
// Shared definitions for the SPI NOR-flash target: opcodes, FSM states,
// status register bit positions and the erase size encoding.
package spi_flash_pkg;

  localparam logic [7:0] CmdProg      = 8'h02;
  localparam logic [7:0] CmdRead      = 8'h03;
  localparam logic [7:0] CmdWrdi      = 8'h04;
  localparam logic [7:0] CmdStatus    = 8'h05;
  localparam logic [7:0] CmdWren      = 8'h06;
  localparam logic [7:0] CmdFastRead  = 8'h0B;
  localparam logic [7:0] CmdErase4k   = 8'h20;
  localparam logic [7:0] CmdDualRead  = 8'h3B;
  localparam logic [7:0] CmdId9e      = 8'h9E;
  localparam logic [7:0] CmdId9f      = 8'h9F;
  localparam logic [7:0] CmdEn4b      = 8'hB7;
  localparam logic [7:0] CmdErase64k  = 8'hD8;
  localparam logic [7:0] CmdEx4b      = 8'hE9;

  typedef enum logic [3:0] {
    StCmd,
    StStatus,
    StAddr,
    StDummy,
    StRead,
    StReadId,
    StProg,
    StErase,
    StIgnore
  } state_e;

  localparam int unsigned StatusWip = 0;
  localparam int unsigned StatusWel = 1;

  localparam logic Erase4k  = 1'b0;
  localparam logic Erase64k = 1'b1;

endpackage

// File: rtl/spi_sync_edge.sv
// Brings the asynchronous SPI pins into the clk domain and detects SPI clock
// edges.
//   clk, reset_n        : system clock, async active-low reset
//   spi_clk/csel_n/mosi : raw SPI pins
//   rise, fall          : one-cycle pulses on synchronised spi_clk edges
//   cs_active           : synchronised chip select asserted
//   mosi_s              : synchronised MOSI, aligned with rise
module spi_sync_edge (
  input  logic clk,
  input  logic reset_n,
  input  logic spi_clk,
  input  logic spi_csel_n,
  input  logic spi_mosi,
  output logic rise,
  output logic fall,
  output logic cs_active,
  output logic mosi_s
);

  // sclk carries one extra stage to hold the previous synchronised value.
  logic [2:0] sclk_q, sclk_d;
  logic [1:0] cs_q, cs_d;
  logic [1:0] mosi_q, mosi_d;

  always_comb begin
    sclk_d = {sclk_q[1:0], spi_clk};
    cs_d   = {cs_q[0], spi_csel_n};
    mosi_d = {mosi_q[0], spi_mosi};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sclk_q <= '0;
      cs_q   <= 2'b11;
      mosi_q <= '0;
    end else begin
      sclk_q <= sclk_d;
      cs_q   <= cs_d;
      mosi_q <= mosi_d;
    end
  end

  assign rise      = sclk_q[1] & ~sclk_q[2];
  assign fall      = ~sclk_q[1] & sclk_q[2];
  assign cs_active = ~cs_q[1];
  assign mosi_s    = mosi_q[1];

endmodule

// File: rtl/spi_flash_target.sv
// Oversampled SPI NOR-flash target running entirely on clk.
//   SPI side    : spi_clk, spi_csel_n, spi_mosi in; spi_io_out/spi_io_oe out
//   read port   : rd_req/rd_addr out, rd_valid/rd_data in
//   program     : wr_strobe/wr_addr/wr_data out
//   erase       : erase_req/erase_addr/erase_size out, busy_done in
//   log         : log_strobe/log_val for every host byte in CMD/ADDR/PROG
module spi_flash_target
  import spi_flash_pkg::*;
#(
  parameter int unsigned ADDR_W       = 25,
  parameter int unsigned DUMMY_CYCLES = 8,
  parameter logic [23:0] JEDEC_ID     = 24'h20BA19,
  parameter bit          DUAL_EN      = 1'b1,
  parameter int unsigned PAGE_W       = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              spi_clk,
  input  logic              spi_csel_n,
  input  logic              spi_mosi,
  output logic [1:0]        spi_io_out,
  output logic [1:0]        spi_io_oe,
  output logic              spi_active,
  output logic              rd_req,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_valid,
  input  logic [7:0]        rd_data,
  output logic              wr_strobe,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              erase_req,
  output logic [ADDR_W-1:0] erase_addr,
  output logic              erase_size,
  input  logic              busy_done,
  output logic              log_strobe,
  output logic [7:0]        log_val
);

  logic rise, fall, cs_active, mosi_s;

  spi_sync_edge u_sync (
    .clk       (clk),
    .reset_n   (reset_n),
    .spi_clk   (spi_clk),
    .spi_csel_n(spi_csel_n),
    .spi_mosi  (spi_mosi),
    .rise      (rise),
    .fall      (fall),
    .cs_active (cs_active),
    .mosi_s    (mosi_s)
  );

  state_e            state_q, state_d;
  logic [7:0]        cmd_q, cmd_d;
  logic [7:0]        bit_cnt_q, bit_cnt_d;
  logic [ADDR_W-2:0] in_sr_q, in_sr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        out_sr_q, out_sr_d;
  logic [1:0]        id_idx_q, id_idx_d;
  logic              wip_q, wip_d, wel_q, wel_d, addr4_q, addr4_d;
  logic [1:0]        io_out_q, io_out_d, io_oe_q, io_oe_d;
  logic              rd_req_q, rd_req_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic              wr_strobe_q, wr_strobe_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]        wr_data_q, wr_data_d;
  logic              erase_req_q, erase_req_d;
  logic [ADDR_W-1:0] erase_addr_q, erase_addr_d;
  logic              erase_size_q, erase_size_d;
  logic              log_strobe_q, log_strobe_d;
  logic [7:0]        log_val_q, log_val_d;

  // in_full is the shift register including the bit arriving this cycle.
  logic [ADDR_W-1:0] in_full;
  logic [7:0]        op, addr_bits, status_byte;
  logic [ADDR_W-1:0] addr_inc, erase_mask;
  logic [PAGE_W-1:0] page_off_inc;
  logic              wip_bd, dual_rd, out_last;

  assign in_full      = {in_sr_q, mosi_s};
  assign op           = in_full[7:0];
  assign addr_bits    = addr4_q ? 8'd32 : 8'd24;
  assign addr_inc     = addr_q + ADDR_W'(1);
  assign page_off_inc = addr_q[PAGE_W-1:0] + PAGE_W'(1);
  assign erase_mask   = (cmd_q == CmdErase64k) ? ({ADDR_W{1'b1}} << 16)
                                               : ({ADDR_W{1'b1}} << 12);
  // busy_done takes effect in the same cycle so a status load sees WIP cleared.
  assign wip_bd       = wip_q & ~busy_done;
  assign dual_rd      = (state_q == StRead) && (cmd_q == CmdDualRead);

  always_comb begin
    status_byte            = 8'h00;
    status_byte[StatusWip] = wip_bd;
    status_byte[StatusWel] = wel_q;
  end

  function automatic logic [7:0] id_byte(input logic [1:0] idx);
    case (idx)
      2'd0:    return JEDEC_ID[7:0];
      2'd1:    return JEDEC_ID[15:8];
      2'd2:    return JEDEC_ID[23:16];
      default: return 8'h00;
    endcase
  endfunction

  always_comb begin
    state_d      = state_q;
    cmd_d        = cmd_q;
    bit_cnt_d    = bit_cnt_q;
    in_sr_d      = in_sr_q;
    addr_d       = addr_q;
    out_sr_d     = out_sr_q;
    id_idx_d     = id_idx_q;
    wip_d        = wip_bd;
    wel_d        = wel_q;
    addr4_d      = addr4_q;
    io_out_d     = io_out_q;
    io_oe_d      = io_oe_q;
    rd_req_d     = 1'b0;
    rd_addr_d    = rd_addr_q;
    wr_strobe_d  = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    erase_req_d  = 1'b0;
    erase_addr_d = erase_addr_q;
    erase_size_d = erase_size_q;
    log_strobe_d = 1'b0;
    log_val_d    = log_val_q;
    out_last     = 1'b0;

    if (!cs_active) begin
      state_d   = StCmd;
      bit_cnt_d = '0;
      io_oe_d   = '0;
      io_out_d  = '0;
    end else if (rise) begin
      in_sr_d   = in_full[ADDR_W-2:0];
      bit_cnt_d = bit_cnt_q + 8'd1;
      if ((state_q inside {StCmd, StAddr, StProg}) && (bit_cnt_q[2:0] == 3'd7)) begin
        log_strobe_d = 1'b1;
        log_val_d    = op;
      end
      unique case (state_q)
        StCmd: begin
          if (bit_cnt_q == 8'd7) begin
            cmd_d     = op;
            bit_cnt_d = '0;
            in_sr_d   = '0;
            if (wip_bd && !(op inside {CmdStatus, CmdId9e, CmdId9f})) begin
              state_d = StIgnore;
            end else begin
              unique case (op)
                CmdStatus: begin
                  state_d  = StStatus;
                  out_sr_d = status_byte;
                end
                CmdWren: begin
                  wel_d   = 1'b1;
                  state_d = StIgnore;
                end
                CmdWrdi: begin
                  wel_d   = 1'b0;
                  state_d = StIgnore;
                end
                CmdEn4b: begin
                  if (wel_q) addr4_d = 1'b1;
                  state_d = StIgnore;
                end
                CmdEx4b: begin
                  if (wel_q) addr4_d = 1'b0;
                  state_d = StIgnore;
                end
                CmdRead, CmdFastRead: state_d = StAddr;
                CmdDualRead: state_d = DUAL_EN ? StAddr : StIgnore;
                CmdProg, CmdErase4k, CmdErase64k: state_d = wel_q ? StAddr : StIgnore;
                CmdId9e, CmdId9f: begin
                  state_d  = StReadId;
                  out_sr_d = id_byte(2'd0);
                  id_idx_d = 2'd1;
                end
                default: state_d = StIgnore;
              endcase
            end
          end
        end
        StAddr: begin
          if (bit_cnt_q == addr_bits - 8'd1) begin
            bit_cnt_d = '0;
            addr_d    = in_full;
            unique case (cmd_q)
              CmdRead: begin
                state_d   = StRead;
                rd_req_d  = 1'b1;
                rd_addr_d = in_full;
              end
              CmdFastRead, CmdDualRead: state_d = StDummy;
              CmdProg: begin
                state_d = StProg;
                wip_d   = 1'b1;
                wel_d   = 1'b0;
              end
              CmdErase4k, CmdErase64k: begin
                state_d      = StErase;
                erase_req_d  = 1'b1;
                erase_addr_d = in_full & erase_mask;
                erase_size_d = (cmd_q == CmdErase64k) ? Erase64k : Erase4k;
                wip_d        = 1'b1;
                wel_d        = 1'b0;
              end
              default: state_d = StIgnore;
            endcase
          end
        end
        StDummy: begin
          if (bit_cnt_q == 8'(DUMMY_CYCLES - 1)) begin
            state_d   = StRead;
            bit_cnt_d = '0;
            rd_req_d  = 1'b1;
            rd_addr_d = addr_q;
          end
        end
        StProg: begin
          if (bit_cnt_q == 8'd7) begin
            bit_cnt_d   = '0;
            wr_strobe_d = 1'b1;
            wr_addr_d   = addr_q;
            wr_data_d   = op;
            addr_d      = {addr_q[ADDR_W-1:PAGE_W], page_off_inc};
          end
        end
        default: bit_cnt_d = bit_cnt_q;
      endcase
    end else if (fall && (state_q inside {StStatus, StRead, StReadId})) begin
      if (dual_rd) begin
        io_out_d = out_sr_q[7:6];
        out_sr_d = {out_sr_q[5:0], 2'b00};
        io_oe_d  = 2'b11;
        out_last = (bit_cnt_q == 8'd3);
      end else begin
        io_out_d = {out_sr_q[7], 1'b0};
        out_sr_d = {out_sr_q[6:0], 1'b0};
        io_oe_d  = 2'b10;
        out_last = (bit_cnt_q == 8'd7);
      end
      bit_cnt_d = out_last ? 8'd0 : bit_cnt_q + 8'd1;
      // Reload on the fall that drives the final bit of the current byte.
      if (out_last) begin
        unique case (state_q)
          StStatus: out_sr_d = status_byte;
          StReadId: begin
            out_sr_d = id_byte(id_idx_q);
            if (id_idx_q != 2'd3) id_idx_d = id_idx_q + 2'd1;
          end
          StRead: begin
            addr_d    = addr_inc;
            rd_req_d  = 1'b1;
            rd_addr_d = addr_inc;
          end
          default: ;
        endcase
      end
    end

    if (cs_active && (state_q == StRead) && rd_valid) out_sr_d = rd_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StCmd;
      cmd_q        <= '0;
      bit_cnt_q    <= '0;
      in_sr_q      <= '0;
      addr_q       <= '0;
      out_sr_q     <= '0;
      id_idx_q     <= '0;
      wip_q        <= 1'b0;
      wel_q        <= 1'b0;
      addr4_q      <= 1'b0;
      io_out_q     <= '0;
      io_oe_q      <= '0;
      rd_req_q     <= 1'b0;
      rd_addr_q    <= '0;
      wr_strobe_q  <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      erase_req_q  <= 1'b0;
      erase_addr_q <= '0;
      erase_size_q <= 1'b0;
      log_strobe_q <= 1'b0;
      log_val_q    <= '0;
    end else begin
      state_q      <= state_d;
      cmd_q        <= cmd_d;
      bit_cnt_q    <= bit_cnt_d;
      in_sr_q      <= in_sr_d;
      addr_q       <= addr_d;
      out_sr_q     <= out_sr_d;
      id_idx_q     <= id_idx_d;
      wip_q        <= wip_d;
      wel_q        <= wel_d;
      addr4_q      <= addr4_d;
      io_out_q     <= io_out_d;
      io_oe_q      <= io_oe_d;
      rd_req_q     <= rd_req_d;
      rd_addr_q    <= rd_addr_d;
      wr_strobe_q  <= wr_strobe_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      erase_req_q  <= erase_req_d;
      erase_addr_q <= erase_addr_d;
      erase_size_q <= erase_size_d;
      log_strobe_q <= log_strobe_d;
      log_val_q    <= log_val_d;
    end
  end

  assign spi_io_out = io_out_q;
  assign spi_io_oe  = io_oe_q;
  assign spi_active = cs_active;
  assign rd_req     = rd_req_q;
  assign rd_addr    = rd_addr_q;
  assign wr_strobe  = wr_strobe_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign erase_req  = erase_req_q;
  assign erase_addr = erase_addr_q;
  assign erase_size = erase_size_q;
  assign log_strobe = log_strobe_q;
  assign log_val    = log_val_q;

endmodule

// File: tb/tb_spi_flash_target.sv
// Directed bench for spi_flash_target: an SPI mode-0 host model plus a memory
// responder that returns rd_addr[7:0] one cycle after each rd_req.
module tb_spi_flash_target;

  localparam int unsigned AW = 25;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          spi_clk = 1'b0;
  logic          spi_csel_n = 1'b1;
  logic          spi_mosi = 1'b0;
  logic          rd_valid = 1'b0;
  logic [7:0]    rd_data = 8'h00;
  logic          busy_done = 1'b0;
  logic [1:0]    spi_io_out, spi_io_oe;
  logic          spi_active, rd_req, wr_strobe, erase_req, erase_size, log_strobe;
  logic [AW-1:0] rd_addr, wr_addr, erase_addr;
  logic [7:0]    wr_data, log_val;

  int vectors = 0;
  int miscompares = 0;

  logic [AW-1:0]   rd_q[$];
  logic [AW+7:0]   wr_q[$];
  logic [7:0]      log_q[$];
  int              erase_cnt = 0;
  logic [AW-1:0]   erase_addr_seen = '0;
  logic            erase_size_seen = 1'b0;
  logic [1:0]      oe_sample = 2'b00;

  spi_flash_target dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .spi_clk   (spi_clk),
    .spi_csel_n(spi_csel_n),
    .spi_mosi  (spi_mosi),
    .spi_io_out(spi_io_out),
    .spi_io_oe (spi_io_oe),
    .spi_active(spi_active),
    .rd_req    (rd_req),
    .rd_addr   (rd_addr),
    .rd_valid  (rd_valid),
    .rd_data   (rd_data),
    .wr_strobe (wr_strobe),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .erase_req (erase_req),
    .erase_addr(erase_addr),
    .erase_size(erase_size),
    .busy_done (busy_done),
    .log_strobe(log_strobe),
    .log_val   (log_val)
  );

  always #5ns clk = ~clk;

  // Memory responder and event monitors, sampled mid-cycle.
  always @(negedge clk) begin
    rd_valid = rd_req;
    rd_data  = rd_addr[7:0];
    if (rd_req) rd_q.push_back(rd_addr);
    if (wr_strobe) wr_q.push_back({wr_addr, wr_data});
    if (log_strobe) log_q.push_back(log_val);
    if (erase_req) begin
      erase_cnt++;
      erase_addr_seen = erase_addr;
      erase_size_seen = erase_size;
    end
  end

  initial begin
    #20ms;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic clear_mon();
    rd_q.delete();
    wr_q.delete();
    log_q.delete();
    erase_cnt = 0;
  endtask

  task automatic spi_start();
    @(negedge clk);
    spi_csel_n = 1'b0;
    #80ns;
  endtask

  task automatic spi_end();
    #80ns;
    spi_csel_n = 1'b1;
    #320ns;
  endtask

  task automatic xfer(input logic [7:0] tx, output logic [7:0] rx);
    for (int i = 7; i >= 0; i--) begin
      spi_mosi = tx[i];
      #80ns;
      rx[i] = spi_io_out[1];
      oe_sample = spi_io_oe;
      spi_clk = 1'b1;
      #80ns;
      spi_clk = 1'b0;
    end
  endtask

  task automatic xfer_dual(output logic [7:0] rx);
    for (int i = 3; i >= 0; i--) begin
      #80ns;
      rx[2*i +: 2] = spi_io_out;
      oe_sample = spi_io_oe;
      spi_clk = 1'b1;
      #80ns;
      spi_clk = 1'b0;
    end
  endtask

  task automatic send_cmd(input logic [7:0] op);
    logic [7:0] d;
    spi_start();
    xfer(op, d);
    spi_end();
  endtask

  task automatic read_status(output logic [7:0] s);
    logic [7:0] d;
    spi_start();
    xfer(8'h05, d);
    xfer(8'h00, s);
    spi_end();
  endtask

  task automatic pulse_busy_done();
    @(negedge clk);
    busy_done = 1'b1;
    @(negedge clk);
    busy_done = 1'b0;
  endtask

  task automatic test_reset();
    logic [7:0] s;
    vectors++;
    if ({spi_io_out, spi_io_oe, spi_active, rd_req, wr_strobe, erase_req, log_strobe} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got %b required 0",
               {spi_io_out, spi_io_oe, spi_active, rd_req, wr_strobe, erase_req, log_strobe});
    end
    read_status(s);
    vectors++;
    if (s !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_status: got %h required 00", s);
    end
  endtask

  task automatic test_single_read();
    logic [7:0] d;
    logic [7:0] rx[3];
    logic [AW-1:0] exp_a[3] = '{25'h100, 25'h101, 25'h102};
    clear_mon();
    spi_start();
    vectors++;
    if (spi_active !== 1'b1) begin
      miscompares++;
      $display("FAIL spi_active: got %b required 1", spi_active);
    end
    xfer(8'h03, d);
    xfer(8'h00, d);
    xfer(8'h01, d);
    xfer(8'h00, d);
    for (int i = 0; i < 3; i++) xfer(8'h00, rx[i]);
    spi_end();
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (rx[i] !== 8'(i)) begin
        miscompares++;
        $display("FAIL read_byte%0d: got %h required %h", i, rx[i], 8'(i));
      end
    end
    vectors++;
    if (oe_sample !== 2'b10) begin
      miscompares++;
      $display("FAIL read_oe: got %b required 10", oe_sample);
    end
    vectors++;
    if (rd_q.size() < 3) begin
      miscompares++;
      $display("FAIL read_addr_count: got %0d required >=3", rd_q.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        vectors++;
        if (rd_q[i] !== exp_a[i]) begin
          miscompares++;
          $display("FAIL read_addr%0d: got %h required %h", i, rd_q[i], exp_a[i]);
        end
      end
    end
    vectors++;
    if (log_q.size() != 4 || log_q[0] !== 8'h03 || log_q[2] !== 8'h01) begin
      miscompares++;
      $display("FAIL read_log: got %0d bytes required 4 (03 00 01 00)", log_q.size());
    end
  endtask

  task automatic test_prog_no_wel();
    logic [7:0] d;
    clear_mon();
    spi_start();
    xfer(8'h02, d);
    xfer(8'h00, d);
    xfer(8'h00, d);
    xfer(8'h10, d);
    xfer(8'hAA, d);
    spi_end();
    vectors++;
    if (wr_q.size() != 0) begin
      miscompares++;
      $display("FAIL prog_no_wel: got %0d writes required 0", wr_q.size());
    end
    read_status(d);
    vectors++;
    if (d !== 8'h00) begin
      miscompares++;
      $display("FAIL prog_no_wel_status: got %h required 00", d);
    end
  endtask

  task automatic test_program();
    logic [7:0] d;
    logic [AW+7:0] exp_w[3] = '{{25'h0FE, 8'h11}, {25'h0FF, 8'h22}, {25'h000, 8'h33}};
    send_cmd(8'h06);
    clear_mon();
    spi_start();
    xfer(8'h02, d);
    xfer(8'h00, d);
    xfer(8'h00, d);
    xfer(8'hFE, d);
    xfer(8'h11, d);
    xfer(8'h22, d);
    xfer(8'h33, d);
    spi_end();
    vectors++;
    if (wr_q.size() != 3) begin
      miscompares++;
      $display("FAIL prog_count: got %0d required 3", wr_q.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        vectors++;
        if (wr_q[i] !== exp_w[i]) begin
          miscompares++;
          $display("FAIL prog_write%0d: got %h required %h", i, wr_q[i], exp_w[i]);
        end
      end
    end
    vectors++;
    if (log_q.size() != 7) begin
      miscompares++;
      $display("FAIL prog_log: got %0d required 7", log_q.size());
    end
    read_status(d);
    vectors++;
    if (d !== 8'h01) begin
      miscompares++;
      $display("FAIL prog_status: got %h required 01", d);
    end
    pulse_busy_done();
    read_status(d);
    vectors++;
    if (d !== 8'h00) begin
      miscompares++;
      $display("FAIL prog_done_status: got %h required 00", d);
    end
  endtask

  task automatic test_erase();
    logic [7:0] d;
    send_cmd(8'h06);
    read_status(d);
    vectors++;
    if (d !== 8'h02) begin
      miscompares++;
      $display("FAIL wren_status: got %h required 02", d);
    end
    clear_mon();
    spi_start();
    xfer(8'hD8, d);
    xfer(8'h01, d);
    xfer(8'h23, d);
    xfer(8'h45, d);
    spi_end();
    vectors++;
    if (erase_cnt != 1 || erase_addr_seen !== 25'h010000 || erase_size_seen !== 1'b1) begin
      miscompares++;
      $display("FAIL erase_req: got n=%0d addr=%h size=%b required n=1 addr=0010000 size=1",
               erase_cnt, erase_addr_seen, erase_size_seen);
    end
    clear_mon();
    spi_start();
    xfer(8'h03, d);
    xfer(8'h00, d);
    xfer(8'h00, d);
    xfer(8'h10, d);
    xfer(8'h00, d);
    spi_end();
    vectors++;
    if (rd_q.size() != 0 || oe_sample !== 2'b00) begin
      miscompares++;
      $display("FAIL read_while_busy: got reqs=%0d oe=%b required reqs=0 oe=00",
               rd_q.size(), oe_sample);
    end
    read_status(d);
    vectors++;
    if (d !== 8'h01) begin
      miscompares++;
      $display("FAIL erase_status: got %h required 01", d);
    end
    pulse_busy_done();
    read_status(d);
    vectors++;
    if (d !== 8'h00) begin
      miscompares++;
      $display("FAIL erase_done_status: got %h required 00", d);
    end
  endtask

  task automatic test_read_id();
    logic [7:0] d;
    logic [7:0] rx[4];
    logic [7:0] exp_id[4] = '{8'h19, 8'hBA, 8'h20, 8'h00};
    spi_start();
    xfer(8'h9F, d);
    for (int i = 0; i < 4; i++) xfer(8'h00, rx[i]);
    spi_end();
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (rx[i] !== exp_id[i]) begin
        miscompares++;
        $display("FAIL read_id%0d: got %h required %h", i, rx[i], exp_id[i]);
      end
    end
  endtask

  task automatic test_dual_read();
    logic [7:0] d, b0, b1;
    logic [1:0] oe_dummy;
    send_cmd(8'h06);
    send_cmd(8'hB7);
    clear_mon();
    oe_dummy = 2'b00;
    spi_start();
    xfer(8'h3B, d);
    xfer(8'h01, d);
    xfer(8'hFF, d);
    xfer(8'hFF, d);
    xfer(8'hFF, d);
    for (int i = 0; i < 8; i++) begin
      #80ns;
      oe_dummy = oe_dummy | spi_io_oe;
      spi_clk = 1'b1;
      #80ns;
      spi_clk = 1'b0;
    end
    xfer_dual(b0);
    xfer_dual(b1);
    spi_end();
    vectors++;
    if (oe_dummy !== 2'b00) begin
      miscompares++;
      $display("FAIL dual_dummy_oe: got %b required 00", oe_dummy);
    end
    vectors++;
    if (b0 !== 8'hFF || b1 !== 8'h00) begin
      miscompares++;
      $display("FAIL dual_data: got %h %h required ff 00", b0, b1);
    end
    vectors++;
    if (oe_sample !== 2'b11) begin
      miscompares++;
      $display("FAIL dual_oe: got %b required 11", oe_sample);
    end
    vectors++;
    if (rd_q.size() < 2 || rd_q[0] !== 25'h1FFFFFF || rd_q[1] !== 25'h0000000) begin
      miscompares++;
      $display("FAIL dual_addr: got n=%0d first=%h required 1ffffff then 0000000",
               rd_q.size(), (rd_q.size() > 0) ? rd_q[0] : 25'h0);
    end
  endtask

  task automatic test_reset_mid_read();
    logic [7:0] d;
    spi_start();
    xfer(8'h03, d);
    xfer(8'h00, d);
    xfer(8'h00, d);
    xfer(8'h00, d);
    xfer(8'h05, d);
    xfer(8'h00, d);
    for (int i = 0; i < 3; i++) begin
      #80ns;
      spi_clk = 1'b1;
      #80ns;
      spi_clk = 1'b0;
    end
    #40ns;
    vectors++;
    if (spi_io_oe !== 2'b10) begin
      miscompares++;
      $display("FAIL mid_read_oe: got %b required 10", spi_io_oe);
    end
    reset_n = 1'b0;
    #1ns;
    vectors++;
    if ({spi_io_out, spi_io_oe, spi_active, rd_req, rd_addr, wr_strobe, wr_addr, wr_data,
         erase_req, erase_addr, erase_size, log_strobe, log_val} !== '0) begin
      miscompares++;
      $display("FAIL reset_mid_read: got oe=%b act=%b rd_addr=%h erase_addr=%h log=%h required 0",
               spi_io_oe, spi_active, rd_addr, erase_addr, log_val);
    end
    spi_csel_n = 1'b1;
    #320ns;
    @(negedge clk);
    reset_n = 1'b1;
    #160ns;
    read_status(d);
    vectors++;
    if (d !== 8'h00) begin
      miscompares++;
      $display("FAIL post_reset_status: got %h required 00", d);
    end
    clear_mon();
    spi_start();
    xfer(8'h03, d);
    xfer(8'h00, d);
    xfer(8'h00, d);
    xfer(8'h07, d);
    xfer(8'h00, d);
    spi_end();
    vectors++;
    if (d !== 8'h07 || rd_q.size() == 0 || rd_q[0] !== 25'h7) begin
      miscompares++;
      $display("FAIL post_reset_3byte: got data=%h reqs=%0d required data=07 addr=0000007",
               d, rd_q.size());
    end
  endtask

  initial begin
    reset_n = 1'b0;
    #100ns;
    @(negedge clk);
    reset_n = 1'b1;
    #100ns;
    test_reset();
    test_single_read();
    test_prog_no_wel();
    test_program();
    test_erase();
    test_read_id();
    test_dual_read();
    test_reset_mid_read();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
